chase_target_monitor: RTL and testbench
=======================================

Name: chase_target_monitor

Overview:
- Sits directly downstream of the innings tracker and consumes its scoreboard outputs: game_state, total_runs, wickets, overs, balls.
- Across a two-innings match, it latches the first-innings total and derives the chase target.
- During the second innings it tracks runs needed and balls remaining.
- It declares the match result: chase won, defence won, or tie.

Parameters:
- MAX_OVERS, 20, overs per innings; must match the tracker's over limit.
- BALLS_PER_OVER, 6, legal deliveries per over.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high; clears all state and outputs immediately.
- new_match  input  1  synchronous pulse; from any state returns to FIRST_INN and clears all latched values.
- game_state  input  2  tracker state: 00 IDLE, 01 PLAYING, 10 INNINGS_OVER.
- total_runs  input  16  tracker run total.
- wickets  input  4  tracker wicket count.
- overs  input  5  tracker completed overs.
- balls  input  3  tracker balls in current over (0..5).
- match_phase  output  2  00 FIRST_INN, 01 BREAK, 10 CHASE, 11 RESULT.
- target  output  17  first-innings total + 1; 0 until latched.
- runs_needed  output  17  runs still required to win.
- balls_remaining  output  7  legal balls left in the chase.
- result  output  2  00 NONE, 01 CHASE_WON, 10 DEFEND_WON, 11 TIE.
- result_valid  output  1  single-cycle pulse on entry to RESULT.

Behaviour:
- Reset values:
  - match_phase=FIRST_INN; target=0; runs_needed=0; result=NONE; result_valid=0.
  - balls_remaining = MAX_OVERS*BALLS_PER_OVER (120 at defaults).
  - Internal prev_state register = IDLE.
- All outputs are registered, giving one cycle of latency from any input change.
- prev_state samples game_state every cycle. over_end = (game_state==10 && prev_state!=10).
- Because prev_state resets to IDLE, an INNINGS_OVER already present at reset release is detected exactly once.
- FIRST_INN:
  - runs_needed=0; balls_remaining held at full quota.
  - On over_end: target <= total_runs+1 (17-bit, no overflow), runs_needed <= total_runs+1, go to BREAK.
- BREAK:
  - The tracker is reset externally (game_state 00), so total_runs is ignored.
  - On game_state==01, go to CHASE.
- CHASE, updated each cycle:
  - runs_needed <= target - total_runs, saturating at 0.
  - balls_remaining <= MAX_OVERS*BALLS_PER_OVER - (overs*BALLS_PER_OVER + balls), saturating at 0.
- Leaving CHASE, first rule wins:
  - (a) total_runs >= target -> result=CHASE_WON.
  - (b) over_end and total_runs == target-1 -> TIE.
  - (c) over_end otherwise -> DEFEND_WON.
  - Each goes to RESULT and asserts result_valid for exactly one cycle.
  - A win and over_end in the same cycle resolves as CHASE_WON.
- RESULT:
  - All outputs hold their final values; result_valid=0 after the entry cycle.
  - Input changes are ignored until new_match or reset.
- new_match:
  - Takes effect on the next posedge and has priority over all transitions.
  - Sets outputs to their reset values, except prev_state, which keeps sampling.
- wickets is informational only. All-out is signalled through game_state=10, so there is no separate wicket check.
- game_state==11 (illegal) is treated as IDLE: no transition.
- Reset asserted mid-chase clears everything asynchronously. After release the block restarts in FIRST_INN.

Test Plan:
- First innings ends at 150 runs (game_state 01->10) -> next cycle: BREAK, target=151, runs_needed=151.
- Chase: tracker at overs=10, balls=3, total=100 -> runs_needed=51, balls_remaining=57.
- Chase total reaches 151 at overs=18, balls=2 -> RESULT, result=01, result_valid high one cycle only; outputs then frozen despite further input changes.
- Chase ends by game_state=10 (20 overs, or 10 wickets) at total=150 -> result=11 (TIE).
  - Separate run ending at total=120 -> result=10 (DEFEND_WON), runs_needed=31, balls_remaining=0.
- Same cycle: total_runs=151 and game_state 01->10 -> result=01 (CHASE_WON).
- Reset asserted between clock edges mid-CHASE -> outputs return to reset values without waiting for a clock edge.
  - new_match pulse in RESULT -> FIRST_INN, target=0, result=00 on next cycle.

Source files
------------

// File: rtl/chase_target_monitor.sv
// Chase target monitor: latches the first-innings total, tracks the chase
// and declares the match result from the innings tracker scoreboard.
module chase_target_monitor #(
  parameter int MAX_OVERS      = 20,
  parameter int BALLS_PER_OVER = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_match,
  input  logic [1:0]  game_state,
  input  logic [15:0] total_runs,
  input  logic [3:0]  wickets,
  input  logic [4:0]  overs,
  input  logic [2:0]  balls,
  output logic [1:0]  match_phase,
  output logic [16:0] target,
  output logic [16:0] runs_needed,
  output logic [6:0]  balls_remaining,
  output logic [1:0]  result,
  output logic        result_valid
);

  typedef enum logic [1:0] {
    FIRST_INN = 2'b00,
    BREAK_PH  = 2'b01,
    CHASE     = 2'b10,
    RESULT    = 2'b11
  } phase_t;

  typedef enum logic [1:0] {
    R_NONE       = 2'b00,
    R_CHASE_WON  = 2'b01,
    R_DEFEND_WON = 2'b10,
    R_TIE        = 2'b11
  } result_t;

  localparam logic [1:0] GS_IDLE = 2'b00;
  localparam logic [1:0] GS_PLAY = 2'b01;
  localparam logic [1:0] GS_OVER = 2'b10;

  localparam int         QUOTA  = MAX_OVERS * BALLS_PER_OVER;
  localparam logic [6:0] FULL   = 7'(QUOTA);

  phase_t      phase, phase_d;
  result_t     res, res_d;
  logic [1:0]  prev_state;
  logic [16:0] target_d;
  logic [16:0] need_d;
  logic [6:0]  left_d;
  logic        valid_d;

  logic [16:0] runs_x;
  logic [31:0] used;
  logic        over_end;
  logic        won;
  logic        tie_hit;

  // All-out arrives as INNINGS_OVER, so the wicket count carries no decision.
  logic unused_wickets;
  assign unused_wickets = ^wickets;

  assign runs_x   = {1'b0, total_runs};
  assign used     = 32'(overs) * 32'(BALLS_PER_OVER) + 32'(balls);
  assign over_end = (game_state == GS_OVER) && (prev_state != GS_OVER);
  assign won      = runs_x >= target;
  assign tie_hit  = runs_x == (target - 17'd1);

  always_comb begin
    phase_d  = phase;
    target_d = target;
    need_d   = runs_needed;
    left_d   = balls_remaining;
    res_d    = res;
    valid_d  = 1'b0;
    if (new_match) begin
      phase_d  = FIRST_INN;
      target_d = '0;
      need_d   = '0;
      left_d   = FULL;
      res_d    = R_NONE;
    end else begin
      unique case (phase)
        FIRST_INN: begin
          need_d = '0;
          left_d = FULL;
          if (over_end) begin
            target_d = runs_x + 17'd1;
            need_d   = runs_x + 17'd1;
            phase_d  = BREAK_PH;
          end
        end
        BREAK_PH: begin
          if (game_state == GS_PLAY) phase_d = CHASE;
        end
        CHASE: begin
          need_d = won ? 17'd0 : target - runs_x;
          left_d = (used < 32'(QUOTA)) ? 7'(32'(QUOTA) - used) : 7'd0;
          // A win on the same edge as the innings end still counts as a win.
          if (won) begin
            res_d   = R_CHASE_WON;
            phase_d = RESULT;
            valid_d = 1'b1;
          end else if (over_end) begin
            res_d   = tie_hit ? R_TIE : R_DEFEND_WON;
            phase_d = RESULT;
            valid_d = 1'b1;
          end
        end
        RESULT: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase           <= FIRST_INN;
      target          <= '0;
      runs_needed     <= '0;
      balls_remaining <= FULL;
      res             <= R_NONE;
      result_valid    <= 1'b0;
      prev_state      <= GS_IDLE;
    end else begin
      phase           <= phase_d;
      target          <= target_d;
      runs_needed     <= need_d;
      balls_remaining <= left_d;
      res             <= res_d;
      result_valid    <= valid_d;
      prev_state      <= game_state;
    end
  end

  assign match_phase = phase;
  assign result      = res;

endmodule

// File: tb/tb_chase_target_monitor.sv
// Bench for chase_target_monitor: directed match scenarios plus random
// matches compared against a match-level reference model.
module tb_chase_target_monitor;

  localparam int MAXO  = 20;
  localparam int BPO   = 6;
  localparam int QUOTA = MAXO * BPO;

  logic        clk;
  logic        reset;
  logic        new_match;
  logic [1:0]  game_state;
  logic [15:0] total_runs;
  logic [3:0]  wickets;
  logic [4:0]  overs;
  logic [2:0]  balls;
  logic [1:0]  match_phase;
  logic [16:0] target;
  logic [16:0] runs_needed;
  logic [6:0]  balls_remaining;
  logic [1:0]  result;
  logic        result_valid;

  int checks = 0;
  int errors = 0;

  int m_phase, m_target, m_need, m_left, m_result, m_valid, m_prev;

  chase_target_monitor #(.MAX_OVERS(MAXO), .BALLS_PER_OVER(BPO)) dut (
    .clk(clk),
    .reset(reset),
    .new_match(new_match),
    .game_state(game_state),
    .total_runs(total_runs),
    .wickets(wickets),
    .overs(overs),
    .balls(balls),
    .match_phase(match_phase),
    .target(target),
    .runs_needed(runs_needed),
    .balls_remaining(balls_remaining),
    .result(result),
    .result_valid(result_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_target = 0; m_need = 0; m_left = QUOTA;
    m_result = 0; m_valid = 0; m_prev = 0;
  endtask

  // Match-level view: one innings total sets the target, the chase ends on a
  // reached target or the innings closing, whichever the scoreboard shows.
  task automatic model_step(input int gs, input int tr, input int ov,
                            input int bl, input bit nm);
    bit oe;
    oe = (gs == 2) && (m_prev != 2);
    m_valid = 0;
    if (nm) begin
      m_phase = 0; m_target = 0; m_need = 0; m_left = QUOTA; m_result = 0;
    end else if (m_phase == 0) begin
      m_need = 0; m_left = QUOTA;
      if (oe) begin
        m_target = tr + 1; m_need = tr + 1; m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (gs == 1) m_phase = 2;
    end else if (m_phase == 2) begin
      m_need = (tr >= m_target) ? 0 : m_target - tr;
      m_left = QUOTA - (ov * BPO + bl);
      if (m_left < 0) m_left = 0;
      if (tr >= m_target) begin
        m_result = 1; m_phase = 3; m_valid = 1;
      end else if (oe) begin
        m_result = (tr == m_target - 1) ? 3 : 2;
        m_phase = 3; m_valid = 1;
      end
    end
    m_prev = gs;
  endtask

  task automatic check_all();
    chk("phase", match_phase, m_phase);
    chk("target", target, m_target);
    chk("runs_needed", runs_needed, m_need);
    chk("balls_remaining", balls_remaining, m_left);
    chk("result", result, m_result);
    chk("result_valid", result_valid, m_valid);
  endtask

  task automatic step(input int gs, input int tr, input int ov,
                      input int bl, input bit nm);
    game_state = 2'(gs);
    total_runs = 16'(tr);
    overs      = 5'(ov);
    balls      = 3'(bl);
    new_match  = nm;
    wickets    = 4'($urandom_range(0, 10));
    @(posedge clk);
    #1;
    model_step(gs, tr, ov, bl, nm);
    check_all();
    new_match = 1'b0;
  endtask

  task automatic play_to_chase(input int r);
    step(1, r, 19, 5, 0);
    step(2, r, 20, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  task automatic innings(input int rate);
    int r, ov, bl;
    r = 0; ov = 0; bl = 0;
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    while (ov < MAXO) begin
      if ($urandom_range(0, 60) == 0) break;
      bl++;
      if (bl == BPO) begin bl = 0; ov++; end
      r += $urandom_range(0, rate);
      if ($urandom_range(0, 30) == 0) step(3, r, ov, bl, 0);
      else step(1, r, ov, bl, 0);
      if ($urandom_range(0, 400) == 0) step(1, r, ov, bl, 1);
    end
    step(2, r, ov, bl, 0);
    step(2, r, ov, bl, 0);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; new_match = 1'b0; game_state = 2'b00;
    total_runs = '0; wickets = '0; overs = '0; balls = '0;
    model_reset();
    #2;
    check_all();
    #1 reset = 1'b0;

    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 150, 19, 5, 0);
    step(2, 150, 20, 0, 0);
    chk("tp_break_phase", match_phase, 1);
    chk("tp_target", target, 151);
    chk("tp_need", runs_needed, 151);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 100, 10, 3, 0);
    chk("tp_need51", runs_needed, 51);
    chk("tp_left57", balls_remaining, 57);
    step(1, 151, 18, 2, 0);
    chk("tp_won", result, 1);
    chk("tp_valid", result_valid, 1);
    step(1, 160, 18, 3, 0);
    chk("tp_valid_once", result_valid, 0);
    step(2, 170, 19, 0, 0);
    chk("tp_frozen", runs_needed, 0);

    step(0, 0, 0, 0, 1);
    chk("tp_nm_target", target, 0);
    play_to_chase(150);
    step(1, 140, 19, 5, 0);
    step(2, 150, 20, 0, 0);
    chk("tp_tie", result, 3);

    step(0, 0, 0, 0, 1);
    play_to_chase(150);
    step(1, 120, 19, 5, 0);
    step(2, 120, 20, 0, 0);
    chk("tp_defend", result, 2);
    chk("tp_defend_need", runs_needed, 31);
    chk("tp_defend_left", balls_remaining, 0);

    step(0, 0, 0, 0, 1);
    play_to_chase(150);
    step(1, 140, 15, 0, 0);
    step(2, 151, 15, 1, 0);
    chk("tp_same_cycle", result, 1);

    step(0, 0, 0, 0, 1);
    play_to_chase(150);
    step(1, 50, 5, 0, 0);
    game_state = 2'b10;
    total_runs = 16'd40;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    step(2, 40, 3, 0, 0);
    chk("tp_over_at_release", target, 41);
    step(2, 40, 3, 0, 0);

    for (int m = 0; m < 30; m++) begin
      step(0, 0, 0, 0, 1);
      innings($urandom_range(1, 3));
      innings($urandom_range(1, 3));
      for (int k = 0; k < 3; k++)
        step($urandom_range(0, 3), $urandom_range(0, 400),
             $urandom_range(0, 20), $urandom_range(0, 5), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
